// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, grant
// sources, control characters and the default print FIFO depth.
package uart_arb_pkg;

  localparam int         PRINT_DEPTH_DEF = 4;
  localparam logic [7:0] CHAR_CR         = 8'h0D;
  localparam logic [7:0] CHAR_LF         = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_ECHO  = 1'b0,
    SRC_PRINT = 1'b1
  } src_e;

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte FIFO for the print channel. A push while full is accepted only when a
// pop happens in the same cycle.
module tx_byte_fifo
  import uart_arb_pkg::*;
#(
  parameter int DEPTH = PRINT_DEPTH_DEF
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [4:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]    count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == 5'(DEPTH));
  assign empty_o = (count_q == 5'd0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Depth is a power of two, so the pointers simply wrap.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between the RX echo path and the accelerator print port,
// inserting an LF after every echoed CR.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int PRINT_DEPTH = PRINT_DEPTH_DEF
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [7:0] echo_byte,
  input  logic       echo_valid,
  input  logic [7:0] print_byte,
  input  logic       print_valid,
  output logic [7:0] tx_byte,
  output logic       tx_wr,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic       busy,
  output logic [4:0] print_count,
  output logic       echo_overflow,
  output logic       print_overflow
);

  logic [1:0]  rst_sync_q;
  logic        rst_n;
  arb_state_e  state_q, state_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        echo_full_q;
  logic [7:0]  echo_data_q;
  logic        lf_pending_q, lf_ready_q;
  src_e        last_grant_q;
  logic        echo_ovf_q, print_ovf_q;
  logic        pop_echo, pop_print, grant_lf, echo_accept;
  logic [7:0]  fifo_data;
  logic        fifo_full, fifo_empty;

  // Reset asserts asynchronously and releases two clk_in edges later.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  tx_byte_fifo #(.DEPTH(PRINT_DEPTH)) u_print_fifo (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .push_i  (print_valid),
    .data_i  (print_byte),
    .pop_i   (pop_print),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (print_count)
  );

  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    pop_echo  = 1'b0;
    pop_print = 1'b0;
    grant_lf  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tx_active && (lf_ready_q || echo_full_q || !fifo_empty)) begin
          state_d = ST_LOAD;
          if (lf_ready_q) begin
            grant_lf  = 1'b1;
            tx_byte_d = CHAR_LF;
          end else if (echo_full_q && (fifo_empty || last_grant_q == SRC_PRINT)) begin
            pop_echo  = 1'b1;
            tx_byte_d = echo_data_q;
          end else begin
            pop_print = 1'b1;
            tx_byte_d = fifo_data;
          end
        end
      end
      ST_LOAD:      state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (tx_done) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign echo_accept = echo_valid && !echo_full_q;

  // The LF becomes requestable only once its CR has left the echo slot, and
  // since the FSM waits for tx_done before rearbitrating it follows that CR.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      echo_full_q  <= 1'b0;
      echo_data_q  <= 8'h00;
      lf_pending_q <= 1'b0;
      lf_ready_q   <= 1'b0;
      last_grant_q <= SRC_PRINT;
      echo_ovf_q   <= 1'b0;
      print_ovf_q  <= 1'b0;
    end else begin
      if (pop_echo) echo_full_q <= 1'b0;
      if (echo_accept) begin
        echo_full_q <= 1'b1;
        echo_data_q <= echo_byte;
        if (echo_byte == CHAR_CR) lf_pending_q <= 1'b1;
      end
      if (pop_echo && lf_pending_q) begin
        lf_pending_q <= 1'b0;
        lf_ready_q   <= 1'b1;
      end
      if (grant_lf)  lf_ready_q   <= 1'b0;
      if (pop_echo)  last_grant_q <= SRC_ECHO;
      if (pop_print) last_grant_q <= SRC_PRINT;
      if (echo_valid && echo_full_q)                 echo_ovf_q  <= 1'b1;
      if (print_valid && fifo_full && !pop_print)    print_ovf_q <= 1'b1;
    end
  end

  assign tx_byte        = tx_byte_q;
  assign tx_wr          = (state_q == ST_LOAD);
  assign busy           = (state_q != ST_IDLE);
  assign echo_overflow  = echo_ovf_q;
  assign print_overflow = print_ovf_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, all
// checked against a queue-based transmit-order model.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int DEPTH = 4;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] echo_byte = 8'h00, print_byte = 8'h00;
  logic       echo_valid = 1'b0, print_valid = 1'b0;
  logic       tx_active = 1'b0, tx_done = 1'b0;
  logic [7:0] tx_byte;
  logic       tx_wr, busy, echo_overflow, print_overflow;
  logic [4:0] print_count;

  always #5 clk_in = ~clk_in;

  uart_tx_arbiter #(.PRINT_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst(rst),
    .echo_byte(echo_byte), .echo_valid(echo_valid),
    .print_byte(print_byte), .print_valid(print_valid),
    .tx_byte(tx_byte), .tx_wr(tx_wr),
    .tx_active(tx_active), .tx_done(tx_done),
    .busy(busy), .print_count(print_count),
    .echo_overflow(echo_overflow), .print_overflow(print_overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: where the current frame is (0 free, 1 strobe, 2 on the
  // wire), the pending echo and print bytes, and what the transmitter shows.
  logic [7:0] e_q[$];
  logic [7:0] p_q[$];
  int         m_phase;
  bit         m_lf, m_last_print, m_eovf, m_povf;
  logic [7:0] m_cur;

  logic [7:0] sent_q[$];
  int         frame_left = 0;
  bit         hold = 0, stray_en = 0;
  int         cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_q.delete(); p_q.delete();
    m_phase = 0; m_lf = 0; m_last_print = 1; m_eovf = 0; m_povf = 0; m_cur = 8'h00;
  endtask

  task automatic model_step(input bit ev, input logic [7:0] eb, input bit pv,
                            input logic [7:0] pb, input bit ta, input bit td);
    bit pop_e, pop_p, e_was_full, p_was_full;
    int nphase;
    pop_e = 0; pop_p = 0; nphase = m_phase;
    e_was_full = (e_q.size() != 0);
    p_was_full = (p_q.size() == DEPTH);
    if (m_phase == 0 && !ta && (m_lf || e_q.size() != 0 || p_q.size() != 0)) begin
      nphase = 1;
      if (m_lf) begin
        m_cur = CHAR_LF; m_lf = 0;
      end else if (e_q.size() != 0 && (p_q.size() == 0 || m_last_print)) begin
        m_cur = e_q[0]; pop_e = 1; m_last_print = 0;
        if (m_cur == CHAR_CR) m_lf = 1;
      end else begin
        m_cur = p_q[0]; pop_p = 1; m_last_print = 1;
      end
    end else if (m_phase == 1) nphase = 2;
    else if (m_phase == 2 && td) nphase = 0;
    m_phase = nphase;
    if (pop_e) void'(e_q.pop_front());
    if (pop_p) void'(p_q.pop_front());
    if (ev) begin
      if (e_was_full) m_eovf = 1; else e_q.push_back(eb);
    end
    if (pv) begin
      if (!p_was_full || pop_p) p_q.push_back(pb); else m_povf = 1;
    end
  endtask

  // One clock cycle: drive inputs (uart_tx behaviour included), compare at the
  // falling edge, advance the model, return just after the next rising edge.
  task automatic cycle(input bit ev, input logic [7:0] eb, input bit pv, input logic [7:0] pb);
    bit ta, td;
    ta = 0; td = 0;
    if (hold) ta = 1;
    else if (frame_left > 0) begin
      ta = 1; td = (frame_left == 1); frame_left--;
    end else if (stray_en) begin
      ta = ($urandom_range(7, 0) == 0);
      td = ($urandom_range(15, 0) == 0);
    end
    echo_valid = ev; echo_byte = eb; print_valid = pv; print_byte = pb;
    tx_active = ta; tx_done = td;
    @(negedge clk_in);
    check_val("tx_wr", 32'(tx_wr), 32'(m_phase == 1));
    check_val("busy", 32'(busy), 32'(m_phase != 0));
    check_val("tx_byte", 32'(tx_byte), 32'(m_cur));
    check_val("print_count", 32'(print_count), 32'(p_q.size()));
    check_val("echo_overflow", 32'(echo_overflow), 32'(m_eovf));
    check_val("print_overflow", 32'(print_overflow), 32'(m_povf));
    if (tx_wr === 1'b1) begin
      sent_q.push_back(tx_byte);
      frame_left = stray_en ? int'($urandom_range(6, 1)) : 3;
    end
    model_step(ev, eb, pv, pb, ta, td);
    cyc++;
    @(posedge clk_in); #1;
    echo_valid = 0; print_valid = 0; tx_done = 0; tx_active = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 8'h00, 0, 8'h00);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (m_phase == 0 && e_q.size() == 0 && p_q.size() == 0 && !m_lf && frame_left == 0) done = 1;
      else idle(1);
    end
    if (!done) check_val("drain_timeout", 32'd0, 32'd1);
  endtask

  // Entered just after a rising edge; reset lands mid-cycle.
  task automatic do_reset();
    #2 rst = 0;
    #1;
    check_val("rst_tx_wr", 32'(tx_wr), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_tx_byte", 32'(tx_byte), 32'd0);
    check_val("rst_print_count", 32'(print_count), 32'd0);
    check_val("rst_echo_ovf", 32'(echo_overflow), 32'd0);
    check_val("rst_print_ovf", 32'(print_overflow), 32'd0);
    model_reset();
    hold = 0; frame_left = 0;
    echo_valid = 0; print_valid = 0; tx_active = 0; tx_done = 0;
    repeat (2) @(posedge clk_in);
    #1 rst = 1;
    idle(3);
  endtask

  task automatic check_sent(input string tag, input int idx, input logic [7:0] exp);
    if (idx < sent_q.size()) check_val(tag, 32'(sent_q[idx]), 32'(exp));
    else check_val({tag, "_missing"}, 32'(sent_q.size()), 32'(idx + 1));
  endtask

  initial begin
    int wr_cyc, start_cyc;
    logic [7:0] next_e;
    bit ev, pv;
    logic [7:0] eb;

    model_reset();
    do_reset();

    // Echo latency: strobe in cycle N gives tx_wr in N+2.
    sent_q.delete();
    start_cyc = cyc; wr_cyc = -1;
    cycle(1, 8'h41, 0, 8'h00);
    for (int k = 0; k < 10 && wr_cyc < 0; k++) begin
      if (sent_q.size() != 0) wr_cyc = cyc - 1;
      else idle(1);
    end
    if (wr_cyc < 0 && sent_q.size() != 0) wr_cyc = cyc - 1;
    check_val("echo_latency", 32'(wr_cyc - start_cyc), 32'd2);
    drain();
    check_sent("echo_byte", 0, 8'h41);

    // CR with a simultaneous print byte: CR, LF, then print.
    do_reset(); sent_q.delete();
    cycle(1, CHAR_CR, 1, 8'h58);
    drain();
    check_val("crlf_len", 32'(sent_q.size()), 32'd3);
    check_sent("crlf_0", 0, 8'h0D);
    check_sent("crlf_1", 1, 8'h0A);
    check_sent("crlf_2", 2, 8'h58);

    // Round robin with both channels requesting each frame.
    do_reset(); sent_q.delete();
    hold = 1;
    cycle(1, 8'h61, 1, 8'h50);
    cycle(0, 8'h00, 1, 8'h51);
    cycle(0, 8'h00, 1, 8'h52);
    hold = 0;
    next_e = 8'h62;
    for (int k = 0; k < 200 && sent_q.size() < 4; k++) begin
      ev = (e_q.size() == 0 && next_e <= 8'h63);
      cycle(ev, next_e, 0, 8'h00);
      if (ev) next_e++;
    end
    drain();
    check_sent("rr_0", 0, 8'h61);
    check_sent("rr_1", 1, 8'h50);
    check_sent("rr_2", 2, 8'h62);
    check_sent("rr_3", 3, 8'h51);

    // Print overflow while the transmitter is held mid-frame.
    do_reset(); sent_q.delete();
    cycle(1, 8'h41, 0, 8'h00);
    idle(2);
    hold = 1;
    for (int k = 0; k < 6; k++) cycle(0, 8'h00, 1, 8'(8'h30 + k));
    check_val("ovf_count", 32'(print_count), 32'd4);
    check_val("ovf_flag", 32'(print_overflow), 32'd1);
    hold = 0;
    drain();
    check_val("ovf_len", 32'(sent_q.size()), 32'd5);
    check_sent("ovf_0", 0, 8'h41);
    for (int k = 0; k < 4; k++) check_sent("ovf_order", k + 1, 8'(8'h30 + k));

    // Reset in the middle of a frame with two bytes queued.
    do_reset(); sent_q.delete();
    cycle(1, 8'h42, 0, 8'h00);
    idle(2);
    hold = 1;
    cycle(0, 8'h00, 1, 8'h70);
    cycle(0, 8'h00, 1, 8'h71);
    idle(1);
    check_val("pre_rst_count", 32'(print_count), 32'd2);
    do_reset(); sent_q.delete();
    idle(10);
    check_val("post_rst_no_wr", 32'(sent_q.size()), 32'd0);

    // Random traffic with a stray-strobe uart_tx and a reset partway through.
    stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      ev = ($urandom_range(3, 0) == 0);
      eb = ($urandom_range(3, 0) == 0) ? CHAR_CR : 8'($urandom);
      pv = ($urandom_range(2, 0) == 0);
      cycle(ev, eb, pv, 8'($urandom));
    end
    stray_en = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter PRINT_DEPTH, default 4, is the print FIFO depth in bytes; it SHALL be a power of two, 2..16.
REQ-002 clk_in  input  1  system clock (100 MHz); all state SHALL be updated on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; it SHALL be asserted asynchronously and deasserted synchronously to clk_in.
REQ-004 echo_byte  input  8  byte received from the UART RX, to be echoed.
REQ-005 echo_valid  input  1  one-cycle strobe qualifying echo_byte.
REQ-006 print_byte  input  8  character from the accelerator print port.
REQ-007 print_valid  input  1  one-cycle strobe qualifying print_byte.
REQ-008 tx_byte  output  8  byte presented to the uart_tx block.
REQ-009 tx_wr  output  1  one-cycle start strobe to uart_tx.
REQ-010 tx_active  input  1  uart_tx is shifting a frame.
REQ-011 tx_done  input  1  one-cycle strobe from uart_tx at the end of a frame.
REQ-012 busy  output  1  high when the FSM is not in IDLE.
REQ-013 print_count  output  5  current print FIFO occupancy.
REQ-014 echo_overflow, print_overflow  output  1 each  sticky drop flags.

Function
REQ-015 Echo channel SHALL hold a 1-entry slot; echo_valid with the slot empty loads it, and echo_valid with the slot full SHALL drop the byte and set echo_overflow.
REQ-016 Accepting 0x0D into the echo slot SHALL set lf_pending; after that CR's tx_done, 0x0A SHALL be sent next, ahead of any other request.
REQ-017 Print channel SHALL be a PRINT_DEPTH FIFO; print_valid when full with no pop in the same cycle SHALL drop and set print_overflow; push and pop in the same cycle at full SHALL accept the push.
REQ-018 FSM states SHALL be IDLE, LOAD and WAIT_DONE.
REQ-019 IDLE: if a request exists and tx_active=0, latch the chosen byte into tx_byte, pop its source, and go to LOAD; otherwise stay in IDLE.
REQ-020 Priority: lf_pending first; otherwise round-robin between echo and print on last_grant; a lone requester SHALL be granted.
REQ-021 LOAD: tx_wr=1 for exactly one cycle, then go to WAIT_DONE.
REQ-022 WAIT_DONE: on tx_done, go to IDLE; tx_done in IDLE or LOAD SHALL be ignored.
REQ-023 tx_byte SHALL stay stable from LOAD until tx_done.
REQ-024 Latency: echo_valid in cycle N with the FSM idle and the slot empty SHALL give tx_wr=1 in cycle N+2.
REQ-025 Sources SHALL keep accepting input during LOAD and WAIT_DONE.
REQ-026 Overflow flags SHALL clear only on reset.
REQ-027 Incoming bytes SHALL be queued or dropped unmodified; the only inserted byte is the LF of REQ-016.

Reset
REQ-028 rst=0 SHALL immediately force: state IDLE, tx_wr=0, tx_byte=0x00, busy=0, print_count=0, both overflow flags 0, echo slot empty, lf_pending=0, and last_grant=print, so echo wins the first tie.
REQ-029 Reset during LOAD or WAIT_DONE SHALL abandon the frame; any in-flight byte is lost and no tx_wr is reissued.

Structure
REQ-030 Shared package uart_arb_pkg SHALL hold the state encoding, CHAR_CR=0x0D, CHAR_LF=0x0A and the PRINT_DEPTH default.
REQ-031 The print FIFO SHALL be sub-module tx_byte_fifo (push, pop, full, empty, count).

Verification
REQ-032 echo_valid with 0x41, FSM idle -> tx_wr exactly 2 cycles later with tx_byte=0x41, then busy until tx_done.
REQ-033 echo 0x0D, plus print 0x58 in the same cycle -> transmitted order 0x0D, 0x0A, 0x58.
REQ-034 echo and print requesting together on 4 consecutive frames -> grants alternate E, P, E, P starting with echo.
REQ-035 6 print strobes while blocked in WAIT_DONE, PRINT_DEPTH=4 -> print_count=4, print_overflow=1, first 4 bytes sent in order.
REQ-036 rst low during WAIT_DONE with 2 bytes queued -> tx_wr=0, busy=0, print_count=0 immediately; no tx_wr after release until new input arrives.
